// File: rtl/instr_decode.sv
// Decode stage: turns raw custom-encoded instruction words into control fields
// and holds up to two decoded entries in an in-order skid queue.
module instr_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [6:0]  out_op,
  output logic [4:0]  out_rd,
  output logic [2:0]  out_funct3,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [31:0] out_imm,
  output logic        out_rd_we,
  output logic        out_rs1_used,
  output logic        out_rs2_used,
  output logic        out_illegal
);

  localparam logic [6:0] OP_ARITH  = 7'b0110011;
  localparam logic [6:0] OP_ARITHI = 7'b0010011;
  localparam logic [6:0] OP_LDUI   = 7'b0110111;
  localparam logic [6:0] OP_LDUIPC = 7'b0010111;
  localparam logic [6:0] OP_LD     = 7'b0000011;
  localparam logic [6:0] OP_ST     = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BR     = 7'b1100011;
  localparam logic [6:0] OP_BRR    = 7'b1101011;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        rd_we;
    logic        rs1_used;
    logic        rs2_used;
    logic        illegal;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } state_t;

  state_t state_q, state_d;
  logic   in_ready_q, in_ready_d;
  entry_t slot0_q, slot0_d;
  entry_t slot1_q, slot1_d;
  entry_t dec;

  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        rd_nz;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic        accept;
  logic        pop;

  assign op     = in_instr[31:25];
  assign funct3 = in_instr[19:17];
  assign rd_nz  = |in_instr[24:20];
  assign imm_i  = {{20{in_instr[11]}}, in_instr[11:0]};
  assign imm_s  = {{20{in_instr[6]}}, in_instr[6:0], in_instr[24:20]};
  assign imm_u  = {in_instr[19:0], 12'b0};
  assign imm_j  = {{11{in_instr[19]}}, in_instr[19:0], 1'b0};

  // Raw fields always pass through; imm and flags are zeroed for illegal words.
  always_comb begin
    dec          = '0;
    dec.pc       = in_pc;
    dec.op       = op;
    dec.rd       = in_instr[24:20];
    dec.funct3   = funct3;
    dec.rs1      = in_instr[16:12];
    dec.rs2      = in_instr[11:7];
    case (op)
      OP_ARITH: begin
        dec.illegal  = |in_instr[6:0];
        dec.rd_we    = rd_nz;
        dec.rs1_used = 1'b1;
        dec.rs2_used = 1'b1;
      end
      OP_ARITHI: begin
        dec.imm      = imm_i;
        dec.rd_we    = rd_nz;
        dec.rs1_used = 1'b1;
      end
      OP_LDUI, OP_LDUIPC: begin
        dec.imm   = imm_u;
        dec.rd_we = rd_nz;
      end
      OP_LD: begin
        dec.illegal  = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        dec.imm      = imm_i;
        dec.rd_we    = rd_nz;
        dec.rs1_used = 1'b1;
      end
      OP_ST: begin
        dec.illegal  = (funct3 > 3'b010);
        dec.imm      = imm_s;
        dec.rs1_used = 1'b1;
        dec.rs2_used = 1'b1;
      end
      OP_JAL: begin
        dec.imm   = imm_j;
        dec.rd_we = rd_nz;
      end
      OP_JALR: begin
        dec.illegal  = (funct3 != 3'b000);
        dec.imm      = imm_i;
        dec.rd_we    = rd_nz;
        dec.rs1_used = 1'b1;
      end
      OP_BR: begin
        dec.imm = imm_j;
      end
      OP_BRR: begin
        dec.imm      = imm_i;
        dec.rs1_used = 1'b1;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
    if (dec.illegal) begin
      dec.imm      = '0;
      dec.rd_we    = 1'b0;
      dec.rs1_used = 1'b0;
      dec.rs2_used = 1'b0;
    end
  end

  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;

  // slot0 is always the oldest entry, so outputs come straight from registers.
  always_comb begin
    state_d = state_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          slot0_d = dec;
        end
      end
      ST_ONE: begin
        if (pop) begin
          if (accept) begin
            slot0_d = dec;
          end else begin
            state_d = ST_EMPTY;
          end
        end else if (accept) begin
          state_d = ST_FULL;
          slot1_d = dec;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_d = ST_ONE;
          slot0_d = slot1_q;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
    end
    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
      slot0_q    <= '0;
      slot1_q    <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_pc       = slot0_q.pc;
  assign out_op       = slot0_q.op;
  assign out_rd       = slot0_q.rd;
  assign out_funct3   = slot0_q.funct3;
  assign out_rs1      = slot0_q.rs1;
  assign out_rs2      = slot0_q.rs2;
  assign out_imm      = slot0_q.imm;
  assign out_rd_we    = slot0_q.rd_we;
  assign out_rs1_used = slot0_q.rs1_used;
  assign out_rs2_used = slot0_q.rs2_used;
  assign out_illegal  = slot0_q.illegal;

endmodule

// File: tb/tb_instr_decode.sv
// Directed bench for instr_decode: expected entries are queued on accept and
// checked in order as the decoder pops them.
module tb_instr_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [6:0]  out_op;
  logic [4:0]  out_rd;
  logic [2:0]  out_funct3;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [31:0] out_imm;
  logic        out_rd_we;
  logic        out_rs1_used;
  logic        out_rs2_used;
  logic        out_illegal;

  instr_decode dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_op(out_op),
    .out_rd(out_rd), .out_funct3(out_funct3), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_imm(out_imm), .out_rd_we(out_rd_we), .out_rs1_used(out_rs1_used),
    .out_rs2_used(out_rs2_used), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        we;
    logic        r1;
    logic        r2;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [31:0] pc_ctr = 32'h1000;
  logic [31:0] held_pc;
  logic [31:0] held_imm;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare the head on every pop, then record any accept.
  always @(negedge clk) begin
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        chk("entry_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          $display("pop pc=%h op=%b imm=%h we=%b r1=%b r2=%b ill=%b",
                   out_pc, out_op, out_imm, out_rd_we, out_rs1_used, out_rs2_used, out_illegal);
          chk("pc", 64'(out_pc), 64'(e.pc));
          chk("fields", 64'({out_op, out_rd, out_funct3, out_rs1, out_rs2}), 64'(e.instr[31:7]));
          chk("imm", 64'(out_imm), 64'(e.imm));
          chk("flags", 64'({out_rd_we, out_rs1_used, out_rs2_used, out_illegal}),
              64'({e.we, e.r1, e.r2, e.ill}));
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(cur);
      end
    end
  end

  task automatic offer(input logic [31:0] instr, input logic [31:0] imm,
                       input logic we, input logic r1, input logic r2, input logic ill);
    in_instr  = instr;
    in_pc     = pc_ctr;
    in_valid  = 1'b1;
    cur.instr = instr;
    cur.pc    = pc_ctr;
    cur.imm   = imm;
    cur.we    = we;
    cur.r1    = r1;
    cur.r2    = r2;
    cur.ill   = ill;
    pc_ctr    = pc_ctr + 32'd4;
  endtask

  // Offers a word and returns just after the edge that accepts it.
  task automatic send(input logic [31:0] instr, input logic [31:0] imm,
                      input logic we, input logic r1, input logic r2, input logic ill);
    int waited;
    offer(instr, imm, we, r1, r2, ill);
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    chk("accepted", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc = '0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_data", 64'({out_pc, out_imm}), 64'd0);
    chk("rst_flags", 64'({out_op, out_rd_we, out_rs1_used, out_rs2_used, out_illegal}), 64'd0);
    chk("rst_in_ready_hold", 64'(in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("in_ready_after_rst", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Streaming with out_ready held high.
    send({7'b0110011, 5'd3, 3'b000, 5'd1, 5'd2, 7'd0},   32'h0,        1, 1, 1, 0);
    send({7'b0010011, 5'd5, 3'b000, 5'd6, 12'hFFF},      32'hFFFFFFFF, 1, 1, 0, 0);
    send({7'b0110111, 5'd7, 20'hABCDE},                   32'hABCDE000, 1, 0, 0, 0);
    send({7'b0010111, 5'd0, 20'h00001},                   32'h00001000, 0, 0, 0, 0);
    send({7'b1101111, 5'd1, 20'h80000},                   32'hFFF00000, 1, 0, 0, 0);
    send({7'b0100011, 5'h1F, 3'b010, 5'd2, 5'd3, 7'h7F}, 32'hFFFFFFFF, 0, 1, 1, 0);
    send({7'b0000011, 5'd4, 3'b010, 5'd8, 12'h004},      32'h00000004, 1, 1, 0, 0);
    send({7'b1100111, 5'd1, 3'b000, 5'd2, 12'h800},      32'hFFFFF800, 1, 1, 0, 0);
    send({7'b1100011, 5'd2, 20'h00010},                   32'h00000020, 0, 0, 0, 0);
    send({7'b1101011, 5'd3, 3'b000, 5'd9, 12'h010},      32'h00000010, 0, 1, 0, 0);
    send({7'b1111111, 25'h0ABCDEF},                       32'h0,        0, 0, 0, 1);
    send({7'b0000011, 5'd4, 3'b110, 5'd1, 12'h123},      32'h0,        0, 0, 0, 1);
    send({7'b0110011, 5'd3, 3'b000, 5'd1, 5'd2, 7'd1},   32'h0,        0, 0, 0, 1);
    send({7'b0110011, 5'd0, 3'b000, 5'd1, 5'd2, 7'd0},   32'h0,        0, 1, 1, 0);
    send({7'b0100011, 5'd1, 3'b011, 5'd2, 5'd3, 7'd0},   32'h0,        0, 0, 0, 1);
    send({7'b1100111, 5'd1, 3'b001, 5'd2, 12'h010},      32'h0,        0, 0, 0, 1);
    idle(4);
    chk("stream_drained", 64'(sb.size()), 64'd0);

    // Backpressure: three words offered, only two fit.
    out_ready = 1'b0;
    offer({7'b0010011, 5'd10, 3'b000, 5'd1, 12'h001}, 32'h1, 1, 1, 0, 0);
    @(negedge clk);
    chk("bp_ready1", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    offer({7'b0010011, 5'd11, 3'b000, 5'd1, 12'h002}, 32'h2, 1, 1, 0, 0);
    @(negedge clk);
    chk("bp_ready2", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    offer({7'b0010011, 5'd12, 3'b000, 5'd1, 12'h003}, 32'h3, 1, 1, 0, 0);
    @(negedge clk);
    chk("bp_full_ready", 64'(in_ready), 64'd0);
    chk("bp_full_valid", 64'(out_valid), 64'd1);
    held_pc  = out_pc;
    held_imm = out_imm;
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_ready", 64'(in_ready), 64'd0);
      chk("bp_hold_out", 64'({out_pc, out_imm}), 64'({held_pc, held_imm}));
    end
    chk("bp_depth", 64'(sb.size()), 64'd2);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("bp_ready_after_pop", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    idle(5);
    chk("bp_drained", 64'(sb.size()), 64'd0);

    // Flush with a full buffer and a word on offer.
    out_ready = 1'b0;
    send({7'b0110111, 5'd1, 20'h11111}, 32'h11111000, 1, 0, 0, 0);
    send({7'b0110111, 5'd2, 20'h22222}, 32'h22222000, 1, 0, 0, 0);
    offer({7'b0110111, 5'd3, 20'h33333}, 32'h33333000, 1, 0, 0, 0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_full_valid", 64'(out_valid), 64'd0);
    chk("flush_full_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    idle(3);

    // Flush while a word is being accepted into a one-entry buffer.
    out_ready = 1'b0;
    send({7'b0110111, 5'd4, 20'h44444}, 32'h44444000, 1, 0, 0, 0);
    offer({7'b0110111, 5'd5, 20'h55555}, 32'h55555000, 1, 0, 0, 0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_one_valid", 64'(out_valid), 64'd0);
    chk("flush_one_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    idle(3);
    chk("flush_nothing_left", 64'(out_valid), 64'd0);

    // Reset and flush together.
    out_ready = 1'b0;
    send({7'b0110111, 5'd6, 20'h66666}, 32'h66666000, 1, 0, 0, 0);
    rst = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("rstfl_valid", 64'(out_valid), 64'd0);
    chk("rstfl_ready", 64'(in_ready), 64'd0);
    chk("rstfl_data", 64'({out_pc, out_imm}), 64'd0);
    chk("rstfl_flags", 64'({out_op, out_rd_we, out_rs1_used, out_rs2_used, out_illegal}), 64'd0);
    @(negedge clk);
    chk("rstfl_ready_back", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // One-cycle reset in the middle of a stream.
    out_ready = 1'b1;
    send({7'b0010011, 5'd7, 3'b000, 5'd2, 12'h077}, 32'h77, 1, 1, 0, 0);
    offer({7'b0010011, 5'd8, 3'b000, 5'd2, 12'h088}, 32'h88, 1, 1, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("mid_rst_ready_back", 64'(in_ready), 64'd1);
    chk("mid_rst_no_entry", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    send({7'b0010011, 5'd9, 3'b000, 5'd2, 12'h099}, 32'h99, 1, 1, 0, 0);
    idle(4);
    chk("final_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
